// File: rtl/logic_pkg.sv
// Shared opcode constants and the bitwise logic function used by the pipeline
// and by anything that needs a reference model of it (widths up to FN_MAX_W).
package logic_pkg;

    localparam int unsigned FN_MAX_W = 64;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_NOTA  = 3'd2;
    localparam logic [2:0] OP_XOR   = 3'd3;
    localparam logic [2:0] OP_NAND  = 3'd4;
    localparam logic [2:0] OP_NOR   = 3'd5;
    localparam logic [2:0] OP_XNOR  = 3'd6;
    localparam logic [2:0] OP_PASSB = 3'd7;

    // Operands are zero-extended by the caller; callers truncate the result
    // back to their own width, so the upper bits never matter.
    function automatic logic [FN_MAX_W-1:0] logic_fn(
        input logic [2:0]          op,
        input logic [FN_MAX_W-1:0] a,
        input logic [FN_MAX_W-1:0] b
    );
        logic [FN_MAX_W-1:0] r;
        case (op)
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_NOTA:  r = ~a;
            OP_XOR:   r = a ^ b;
            OP_NAND:  r = ~(a & b);
            OP_NOR:   r = ~(a | b);
            OP_XNOR:  r = ~(a ^ b);
            default:  r = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_flags.sv
// Result flags derived from a WIDTH-bit value: all-zero, all-ones and
// XOR-reduction parity. Purely combinational.
module logic_flags #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ones,
    output logic             parity
);

    assign zero   = (y == '0);
    assign ones   = &y;
    assign parity = ^y;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined WIDTH-bit logic unit with an optional accumulator as
// operand A, valid/ready on both sides, result flags and a completion counter.
import logic_pkg::*;

module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ones,
    output logic             parity,
    output logic [CNT_W-1:0] done_cnt
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_r;
    logic             s2_valid;
    logic [WIDTH-1:0] acc;

    logic             accept;
    logic             s1_adv;
    logic             out_fire;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] r_in;
    logic             f_zero;
    logic             f_ones;
    logic             f_parity;

    // Handshake: a beat transfers on a side when valid && ready are both high
    // at a rising edge. The sender holds its payload stable while
    // valid && !ready; on the output side this unit holds y and the flags.
    // A full pipe can still accept when the output drains in the same cycle.
    assign in_ready = rst_n && (!s1_valid || !s2_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign s1_adv   = s1_valid && (!s2_valid || out_ready);
    assign out_fire = s2_valid && out_ready;

    assign a_eff = acc_en ? acc : a;
    assign r_in  = WIDTH'(logic_fn(op, FN_MAX_W'(a_eff), FN_MAX_W'(b)));

    logic_flags #(
        .WIDTH(WIDTH)
    ) u_flags (
        .y      (s1_r),
        .zero   (f_zero),
        .ones   (f_ones),
        .parity (f_parity)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_r     <= r_in;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            y        <= '0;
            zero     <= 1'b0;
            ones     <= 1'b0;
            parity   <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            y        <= s1_r;
            zero     <= f_zero;
            ones     <= f_ones;
            parity   <= f_parity;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    // The beat has already read the old acc through a_eff; clear still wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (accept && acc_en) begin
            acc <= r_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (out_fire) begin
            done_cnt <= done_cnt + CNT_W'(1);
        end
    end

    assign out_valid = s2_valid;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: scenario tasks drive beats, a reference model
// pushes expected results at accept time and each task compares them on output.
import logic_pkg::*;

module tb_logic_unit_pipe;

    localparam int W = 8;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2:0]    op;
    logic          acc_en;
    logic          acc_clr;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  y;
    logic          zero;
    logic          ones;
    logic          parity;
    logic [CW-1:0] done_cnt;

    logic_unit_pipe #(
        .WIDTH(W),
        .CNT_W(CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .ones      (ones),
        .parity    (parity),
        .done_cnt  (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic         en;
        logic         clr;
    } beat_t;

    typedef struct {
        bit           acc;
        bit           fire;
        logic         ov;
        logic         ir;
        logic [W-1:0] y;
        logic         zero;
        logic         ones;
        logic         parity;
        int           cyc;
    } obs_t;

    logic [W-1:0] exp_q[$];
    int           cyc_q[$];
    beat_t        beats[$];
    logic [W-1:0] acc_m;
    int           n_done;
    int           cyc;
    int           n_checks;
    int           n_fail;

    // Drive beat k of the current stream, or idle once the stream is exhausted.
    task automatic present(input int k);
        if (k < beats.size()) begin
            in_valid = 1'b1;
            a        = beats[k].a;
            b        = beats[k].b;
            op       = beats[k].op;
            acc_en   = beats[k].en;
            acc_clr  = beats[k].clr;
        end else begin
            in_valid = 1'b0;
            acc_en   = 1'b0;
            acc_clr  = 1'b0;
        end
    endtask

    // Samples the DUT just after the inputs settle, updates the reference
    // model for whatever the coming rising edge will do, then waits a cycle.
    task automatic tick(output obs_t o);
        logic [W-1:0]        a_e;
        logic [FN_MAX_W-1:0] r64;
        #1;
        o.acc    = (in_valid && in_ready);
        o.fire   = (out_valid && out_ready);
        o.ov     = out_valid;
        o.ir     = in_ready;
        o.y      = y;
        o.zero   = zero;
        o.ones   = ones;
        o.parity = parity;
        o.cyc    = cyc;
        if (o.fire) n_done++;
        if (o.acc) begin
            a_e = acc_en ? acc_m : a;
            r64 = logic_fn(op, FN_MAX_W'(a_e), FN_MAX_W'(b));
            exp_q.push_back(r64[W-1:0]);
            cyc_q.push_back(cyc);
            if (acc_en) acc_m = r64[W-1:0];
        end
        if (acc_clr) acc_m = '0;
        if (!rst_n) begin
            acc_m  = '0;
            n_done = 0;
            exp_q.delete();
            cyc_q.delete();
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic pop_exp(output logic [W-1:0] e, output int ec, output bit ok);
        ok = (exp_q.size() > 0);
        e  = '0;
        ec = 0;
        if (ok) begin
            e  = exp_q.pop_front();
            ec = cyc_q.pop_front();
        end
    endtask

    task automatic test_reset();
        obs_t o;
        rst_n = 1'b0; in_valid = 1'b1; a = 8'h5A; b = 8'hA5; op = OP_XOR;
        acc_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(o);
            #1;
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || y !== '0 || done_cnt !== '0) begin
                n_fail++;
                $display("FAIL reset_state cycle %0d: in_ready=%b out_valid=%b y=%h done_cnt=%0d, required 0 0 00 0",
                         i, in_ready, out_valid, y, done_cnt);
            end
        end
        rst_n = 1'b1; in_valid = 1'b0;
        tick(o);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_truth();
        obs_t o; logic [W-1:0] e; int ec; bit ok;
        logic [3:0] tt[8];
        int k, n_out;
        tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0011; tt[3] = 4'b0110;
        tt[4] = 4'b0111; tt[5] = 4'b0001; tt[6] = 4'b1001; tt[7] = 4'b1010;
        beats.delete();
        for (int i = 0; i < 8; i++) beats.push_back('{8'hCC, 8'hAA, 3'(i), 1'b0, 1'b0});
        out_ready = 1'b1; k = 0; n_out = 0;
        for (int c = 0; c < 40; c++) begin
            present(k); tick(o);
            if (o.acc) k++;
            if (o.fire) begin
                pop_exp(e, ec, ok);
                n_checks++;
                if (!ok || o.y !== e || n_out >= 8 || o.y[3:0] !== tt[n_out & 7]) begin
                    n_fail++;
                    $display("FAIL truth_y op %0d: got %h expected %h (nibble %b)", n_out, o.y, e, tt[n_out & 7]);
                end
                n_checks++;
                if (o.cyc - ec !== 2) begin
                    n_fail++;
                    $display("FAIL truth_latency op %0d: got %0d cycles required 2", n_out, o.cyc - ec);
                end
                n_out++;
            end
            if (k == beats.size() && exp_q.size() == 0) break;
        end
        #1;
        n_checks++;
        if (n_out !== 8 || done_cnt !== CW'(8)) begin
            n_fail++;
            $display("FAIL truth_count: outputs=%0d done_cnt=%0d required 8 8", n_out, done_cnt);
        end
    endtask

    task automatic test_backpressure();
        obs_t o; logic [W-1:0] e; int ec; bit ok;
        logic [W-1:0] y_hold; bit have_y;
        int k, n_out;
        beats.delete();
        for (int i = 0; i < 5; i++)
            beats.push_back('{W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                              3'($urandom_range(0, 7)), 1'b0, 1'b0});
        out_ready = 1'b0; k = 0; n_out = 0; have_y = 0; y_hold = '0;
        for (int c = 0; c < 6; c++) begin
            present(k); tick(o);
            if (k >= 2) begin
                n_checks++;
                if (o.ir !== 1'b0 || o.acc) begin
                    n_fail++;
                    $display("FAIL bp_in_ready cycle %0d: in_ready=%b required 0", c, o.ir);
                end
            end
            if (o.ov === 1'b1) begin
                if (have_y) begin
                    n_checks++;
                    if (o.y !== y_hold) begin
                        n_fail++;
                        $display("FAIL bp_y_stable cycle %0d: got %h required %h", c, o.y, y_hold);
                    end
                end
                have_y = 1; y_hold = o.y;
            end
            if (o.acc) k++;
        end
        n_checks++;
        if (k !== 2) begin
            n_fail++;
            $display("FAIL bp_accepts: got %0d required 2", k);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            present(k); tick(o);
            if (o.acc) k++;
            if (o.fire) begin
                pop_exp(e, ec, ok);
                n_checks++;
                if (!ok || o.y !== e) begin
                    n_fail++;
                    $display("FAIL bp_y beat %0d: got %h expected %h", n_out, o.y, e);
                end
                n_out++;
            end
            if (k == beats.size() && exp_q.size() == 0) break;
        end
        n_checks++;
        if (n_out !== 5) begin
            n_fail++;
            $display("FAIL bp_count: got %0d results required 5", n_out);
        end
    endtask

    task automatic test_accumulate();
        obs_t o; logic [W-1:0] e; int ec; bit ok;
        logic [W-1:0] yc[3];
        int k, n_out;
        yc[0] = 8'h0F; yc[1] = 8'hF0; yc[2] = 8'h30;
        out_ready = 1'b1; in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b1;
        tick(o);
        acc_clr = 1'b0;
        beats.delete();
        beats.push_back('{W'($urandom_range(0, 255)), 8'h0F, OP_OR,  1'b1, 1'b0});
        beats.push_back('{W'($urandom_range(0, 255)), 8'hFF, OP_XOR, 1'b1, 1'b0});
        beats.push_back('{W'($urandom_range(0, 255)), 8'h3C, OP_AND, 1'b1, 1'b0});
        k = 0; n_out = 0;
        for (int c = 0; c < 30; c++) begin
            present(k); tick(o);
            if (o.acc) k++;
            if (o.fire) begin
                pop_exp(e, ec, ok);
                n_checks++;
                if (!ok || o.y !== e || n_out >= 3 || o.y !== yc[n_out % 3] ||
                    o.parity !== 1'b0 || o.ones !== 1'b0) begin
                    n_fail++;
                    $display("FAIL acc_y beat %0d: got y=%h parity=%b ones=%b required y=%h parity=0 ones=0",
                             n_out, o.y, o.parity, o.ones, yc[n_out % 3]);
                end
                n_out++;
            end
            if (k == beats.size() && exp_q.size() == 0) break;
        end
        n_checks++;
        if (n_out !== 3) begin
            n_fail++;
            $display("FAIL acc_count: got %0d results required 3", n_out);
        end
    endtask

    task automatic test_flags();
        obs_t o; logic [W-1:0] e; int ec; bit ok;
        logic [2:0] fc[3];
        int k, n_out;
        fc[0] = 3'b100; fc[1] = 3'b010; fc[2] = 3'b001;
        beats.delete();
        beats.push_back('{W'($urandom_range(0, 255)), 8'h00, OP_PASSB, 1'b0, 1'b0});
        beats.push_back('{W'($urandom_range(0, 255)), 8'hFF, OP_PASSB, 1'b0, 1'b0});
        beats.push_back('{W'($urandom_range(0, 255)), 8'h01, OP_PASSB, 1'b0, 1'b0});
        out_ready = 1'b1; k = 0; n_out = 0;
        for (int c = 0; c < 30; c++) begin
            present(k); tick(o);
            if (o.acc) k++;
            if (o.fire) begin
                pop_exp(e, ec, ok);
                n_checks++;
                if (!ok || o.y !== e || n_out >= 3 || {o.zero, o.ones, o.parity} !== fc[n_out % 3]) begin
                    n_fail++;
                    $display("FAIL flags beat %0d: got y=%h zop=%b required y=%h zop=%b",
                             n_out, o.y, {o.zero, o.ones, o.parity}, e, fc[n_out % 3]);
                end
                n_out++;
            end
            if (k == beats.size() && exp_q.size() == 0) break;
        end
        n_checks++;
        if (n_out !== 3) begin
            n_fail++;
            $display("FAIL flags_count: got %0d results required 3", n_out);
        end
    endtask

    task automatic test_clr_same_cycle();
        obs_t o; logic [W-1:0] e; int ec; bit ok;
        logic [W-1:0] yc[3];
        int k, n_out;
        yc[0] = 8'h5A; yc[1] = 8'hA5; yc[2] = 8'h00;
        out_ready = 1'b1; in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b1;
        tick(o);
        beats.delete();
        beats.push_back('{8'h00, 8'h5A, OP_OR,  1'b1, 1'b0});
        beats.push_back('{8'h00, 8'hFF, OP_XOR, 1'b1, 1'b1});
        beats.push_back('{8'hFF, 8'h00, OP_OR,  1'b1, 1'b0});
        k = 0; n_out = 0;
        for (int c = 0; c < 30; c++) begin
            present(k); tick(o);
            if (o.acc) k++;
            if (o.fire) begin
                pop_exp(e, ec, ok);
                n_checks++;
                if (!ok || o.y !== e || n_out >= 3 || o.y !== yc[n_out % 3]) begin
                    n_fail++;
                    $display("FAIL clr_same_cycle beat %0d: got %h required %h", n_out, o.y, yc[n_out % 3]);
                end
                n_out++;
            end
            if (k == beats.size() && exp_q.size() == 0) break;
        end
        n_checks++;
        if (n_out !== 3) begin
            n_fail++;
            $display("FAIL clr_count: got %0d results required 3", n_out);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o; logic [W-1:0] e; int ec; bit ok;
        int k, n_out;
        beats.delete();
        for (int i = 0; i < 30; i++)
            beats.push_back('{W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                              ($urandom_range(0, 7) == 0)});
        k = 0; n_out = 0;
        for (int c = 0; c < 300; c++) begin
            present(k);
            out_ready = ($urandom_range(0, 3) != 0);
            tick(o);
            if (o.acc) k++;
            if (o.fire) begin
                pop_exp(e, ec, ok);
                n_checks++;
                if (!ok || o.y !== e || o.zero !== (e == '0) || o.ones !== (&e) || o.parity !== (^e)) begin
                    n_fail++;
                    $display("FAIL b2b_y beat %0d: got y=%h zop=%b expected y=%h zop=%b", n_out, o.y,
                             {o.zero, o.ones, o.parity}, e, {(e == '0), (&e), (^e)});
                end
                n_out++;
            end
            if (k == beats.size() && exp_q.size() == 0) break;
        end
        #1;
        n_checks++;
        if (n_out !== 30 || done_cnt !== CW'(n_done)) begin
            n_fail++;
            $display("FAIL b2b_count: outputs=%0d done_cnt=%0d required 30 %0d", n_out, done_cnt, CW'(n_done));
        end
        out_ready = 1'b1;
    endtask

    task automatic test_mid_reset();
        obs_t o; logic [W-1:0] e; int ec; bit ok;
        int k, n_out;
        beats.delete();
        beats.push_back('{8'h00, 8'h77, OP_OR, 1'b1, 1'b0});
        beats.push_back('{8'h00, 8'h88, OP_OR, 1'b1, 1'b0});
        out_ready = 1'b0;
        present(0); tick(o);
        present(1); tick(o);
        in_valid = 1'b0; acc_en = 1'b0; rst_n = 1'b0;
        tick(o);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(o);
            n_checks++;
            if (o.ov !== 1'b0 || o.fire) begin
                n_fail++;
                $display("FAIL mid_reset_out_valid cycle %0d: out_valid=%b required 0", c, o.ov);
            end
        end
        #1;
        n_checks++;
        if (done_cnt !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_done_cnt: got %0d required 0", done_cnt);
        end
        beats.delete();
        beats.push_back('{8'hFF, 8'h00, OP_OR, 1'b1, 1'b0});
        k = 0; n_out = 0;
        for (int c = 0; c < 20; c++) begin
            present(k); tick(o);
            if (o.acc) k++;
            if (o.fire) begin
                pop_exp(e, ec, ok);
                n_checks++;
                if (!ok || o.y !== e || o.y !== 8'h00) begin
                    n_fail++;
                    $display("FAIL mid_reset_acc: got %h required 00", o.y);
                end
                n_out++;
            end
            if (k == beats.size() && exp_q.size() == 0) break;
        end
        #1;
        n_checks++;
        if (n_out !== 1 || done_cnt !== CW'(1)) begin
            n_fail++;
            $display("FAIL mid_reset_count: outputs=%0d done_cnt=%0d required 1 1", n_out, done_cnt);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; n_done = 0; cyc = 0; acc_m = '0;
        test_reset();
        test_truth();
        test_backpressure();
        test_accumulate();
        test_flags();
        test_clr_same_cycle();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the single-bit structural AND/OR/NOT gates.
- WIDTH-bit bitwise logic unit with 8 selectable operations, valid/ready handshake on both sides, 2-stage pipeline, optional accumulate mode and result flags.
- Sits between a stimulus/register source and any ready-driven consumer.
- Also serves as the team's standard handshake and pipeline teaching block.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- CNT_W, 16, width of the completed-result counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat.
- a  in  WIDTH  operand A (ignored when acc_en=1).
- b  in  WIDTH  operand B.
- op  in  3  0 AND, 1 OR, 2 NOT a, 3 XOR, 4 NAND, 5 NOR, 6 XNOR, 7 PASS b.
- acc_en  in  1  sampled with beat; use accumulator as operand A.
- acc_clr  in  1  clear accumulator to 0 (level, any cycle).
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- y  out  WIDTH  result.
- zero  out  1  y == 0.
- ones  out  1  y == all ones.
- parity  out  1  XOR-reduction of y.
- done_cnt  out  CNT_W  number of result beats accepted downstream.

Behaviour:
- Reset (rst_n=0 at rising edge):
  - s1_valid, s2_valid, out_valid = 0.
  - y, zero, ones, parity, done_cnt = 0; accumulator = 0.
  - Takes effect mid-operation too: in-flight beats are discarded and no output is produced for them.
- in_ready is combinational and equals !s1_valid || !s2_valid || out_ready. It is forced to 0 while rst_n=0.
- Handshake: a beat is accepted when in_valid && in_ready, or out_valid && out_ready. Producers hold data stable while valid && !ready. Unit holds y and flags stable while out_valid && !out_ready.
- Stage 1 (on accept):
  - Register a_eff = acc_en ? acc : a, plus b and op.
  - Compute r = f(op, a_eff, b) combinationally on the input side and register it.
- Stage 2:
  - Advances when s1_valid && (!s2_valid || out_ready).
  - Registers y = r, zero, ones, parity.
  - out_valid = s2_valid.
- Latency: 2 cycles from accept to out_valid with no backpressure. Full throughput of 1 beat/cycle.
- Stall: with out_ready=0, stage 2 holds and stage 1 fills. in_ready drops after 2 beats are held, so no beat is ever lost or duplicated.
- Accumulator:
  - On an accepted beat with acc_en=1: acc <= f(op, acc, b).
  - Back-to-back accumulate beats chain correctly because the update happens at accept.
  - Accepted beats with acc_en=0 leave acc unchanged.
- acc_clr and accept in the same cycle:
  - The beat uses the old acc as operand.
  - acc ends at 0; clear wins.
- op=2 (NOT) ignores b. op=7 (PASS b) ignores a_eff.
- done_cnt increments on each out_valid && out_ready and wraps modulo 2^CNT_W.
- Simultaneous stage-2 drain and stage-1 fill in the same cycle is legal and required for full throughput.

Decomposition:
- Shared package logic_pkg:
  - Opcode constants OP_AND..OP_PASSB (3-bit).
  - A logic_fn function f(op, a, b) parametrised by width. It is reused by the bench's scoreboard.
- Sub-module logic_flags (WIDTH): combinational zero/ones/parity from y. It is instantiated once, feeding the stage-2 flag registers.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, y=0, done_cnt=0. Release -> in_ready=1 on the next cycle.
- Truth table:
  - WIDTH=4, a=4'b1100, b=4'b1010, op 0..7, out_ready=1.
  - Expected y = 1000, 1110, 0011, 0110, 0111, 0001, 1001, 1010.
  - Each y appears 2 cycles after its accept; done_cnt=8 at the end.
- Backpressure:
  - Stream 5 beats with out_ready=0 -> in_ready=0 after 2 accepts, y held stable.
  - Then out_ready=1 -> all 5 results appear in order, none lost or duplicated.
- Accumulate (WIDTH=8):
  - acc_clr pulse, then acc_en=1 beats (OR b=0x0F), (XOR b=0xFF), (AND b=0x3C) -> y = 0x0F, 0xF0, 0x30.
  - Flags: parity=0,0,0 and ones=0 on all three.
- Flags: WIDTH=8, op=PASS, b=0x00 -> zero=1. b=0xFF -> ones=1, parity=0. b=0x01 -> parity=1.
- Mid-operation reset: accept 2 beats, assert rst_n=0 for 1 cycle before the first reaches output -> out_valid stays 0, acc=0, done_cnt=0.
